// File: rtl/regfile_writeback_pkg.sv
// Shared processor types for the register-file write-back stage.
// Holds register geometry plus the buffered-write entry and source encodings.
package regfile_writeback_pkg;

  localparam int REGISTER_ADDRESS_BITS = 5;
  localparam int REGISTER_DATA_BITS    = 32;

  typedef struct packed {
    logic [REGISTER_ADDRESS_BITS-1:0] addr;
    logic [REGISTER_DATA_BITS-1:0]    data;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: synchronous FIFO of write-back entries with count and head view.
// With REGFILE_WB_PENDING_EN defined it also exposes every slot and its valid bit.
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef REGFILE_WB_PENDING_EN
  ,
  output wb_entry_t [DEPTH-1:0]    entries,
  output logic [DEPTH-1:0]         entry_valid
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: validity is tracked purely by pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_entry;
  end

`ifdef REGFILE_WB_PENDING_EN
  always_comb begin
    logic [PTR_W-1:0] offs;
    offs        = '0;
    entries     = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs           = PTR_W'(i) - rd_ptr;
      entries[i]     = slots[i];
      entry_valid[i] = ({1'b0, offs} < count);
    end
  end
`endif

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage: arbitrates ALU/load results into a FIFO and drains one register write per cycle.
// Optional read-after-write pending outputs are built when REGFILE_WB_PENDING_EN is defined.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             alu_valid,
  input  logic [REGISTER_ADDRESS_BITS-1:0] alu_addr,
  input  logic [REGISTER_DATA_BITS-1:0]    alu_data,
  output logic                             alu_ready,
  input  logic                             mem_valid,
  input  logic [REGISTER_ADDRESS_BITS-1:0] mem_addr,
  input  logic [REGISTER_DATA_BITS-1:0]    mem_data,
  output logic                             mem_ready,
  input  logic                             wr_hold,
  output logic [REGISTER_ADDRESS_BITS-1:0] wr_addr,
  output logic                             wr_enable,
  output logic [REGISTER_DATA_BITS-1:0]    wr_data
`ifdef REGFILE_WB_PENDING_EN
  ,
  input  logic [REGISTER_ADDRESS_BITS-1:0] rd0_addr,
  input  logic [REGISTER_ADDRESS_BITS-1:0] rd1_addr,
  output logic                             rd0_pending,
  output logic                             rd1_pending
`endif
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;
  logic                can_accept;
  logic                grant_valid;
  wb_src_e             grant_src;
  wb_entry_t           push_entry;
  wb_entry_t           head;
  logic [STARVE_W-1:0] starve_cnt;

`ifdef REGFILE_WB_PENDING_EN
  wb_entry_t [FIFO_DEPTH-1:0] entries;
  logic [FIFO_DEPTH-1:0]      entry_valid;
`endif

  // A full FIFO accepts nothing even on a draining cycle (no pass-through path).
  assign can_accept = reset && (count < CNT_W'(FIFO_DEPTH));

  always_comb begin
    grant_valid = 1'b0;
    grant_src   = WB_SRC_MEM;
    if (can_accept) begin
      if (mem_valid && alu_valid) begin
        grant_valid = 1'b1;
        grant_src   = (starve_cnt == STARVE_W'(STARVE_LIMIT)) ? WB_SRC_ALU : WB_SRC_MEM;
      end else if (mem_valid) begin
        grant_valid = 1'b1;
        grant_src   = WB_SRC_MEM;
      end else if (alu_valid) begin
        grant_valid = 1'b1;
        grant_src   = WB_SRC_ALU;
      end
    end
  end

  assign alu_ready = grant_valid && (grant_src == WB_SRC_ALU);
  assign mem_ready = grant_valid && (grant_src == WB_SRC_MEM);

  always_comb begin
    push_entry      = '0;
    push_entry.addr = (grant_src == WB_SRC_ALU) ? alu_addr : mem_addr;
    push_entry.data = (grant_src == WB_SRC_ALU) ? alu_data : mem_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (full) begin
      starve_cnt <= starve_cnt;
    end else if (!alu_valid || alu_ready) begin
      starve_cnt <= '0;
    end else if (mem_ready && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (grant_valid),
    .push_entry (push_entry),
    .pop        (wr_enable),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
`ifdef REGFILE_WB_PENDING_EN
    ,
    .entries     (entries),
    .entry_valid (entry_valid)
`endif
  );

  assign wr_enable = reset && !empty && !wr_hold;
  assign wr_addr   = (reset && !empty) ? head.addr : '0;
  assign wr_data   = (reset && !empty) ? head.data : '0;

`ifdef REGFILE_WB_PENDING_EN
  // The head entry counts as pending even on the cycle it is being written.
  always_comb begin
    rd0_pending = 1'b0;
    rd1_pending = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i] && (entries[i].addr == rd0_addr)) rd0_pending = 1'b1;
      if (entry_valid[i] && (entries[i].addr == rd1_addr)) rd1_pending = 1'b1;
    end
    if (!reset) begin
      rd0_pending = 1'b0;
      rd1_pending = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model, write scoreboard, directed and random phases.
// Exercises the pending outputs too when REGFILE_WB_PENDING_EN is defined.
`timescale 1ns/1ps
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
  localparam int AW    = REGISTER_ADDRESS_BITS;
  localparam int DW    = REGISTER_DATA_BITS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          alu_valid, mem_valid, wr_hold;
  logic [AW-1:0] alu_addr, mem_addr;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready, wr_enable;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`ifdef REGFILE_WB_PENDING_EN
  logic [AW-1:0] rd0_addr, rd1_addr;
  logic          rd0_pending, rd1_pending;
`endif

  always #5 clk = ~clk;

  regfile_writeback #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .wr_hold   (wr_hold),
    .wr_addr   (wr_addr),
    .wr_enable (wr_enable),
    .wr_data   (wr_data)
`ifdef REGFILE_WB_PENDING_EN
    ,
    .rd0_addr    (rd0_addr),
    .rd1_addr    (rd1_addr),
    .rd0_pending (rd0_pending),
    .rd1_pending (rd1_pending)
`endif
  );

  int            checks = 0;
  int            passed = 0;
  wb_entry_t     exp_q[$];
  wb_entry_t     mq[$];
  logic [AW-1:0] log_q[$];
  int            losses = 0;
  logic          alu_acc, mem_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: every register write must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && wr_enable === 1'b1) begin
        log_q.push_back(wr_addr);
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wb_entry_t e;
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
      end
    end
  end

  // Reference model: a queue of buffered writes plus an ALU losing-streak counter.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!reset) begin
        mq.delete();
        exp_q.delete();
        losses = 0;
        chk("rst_wr_enable", wr_enable, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
      end else begin
        bit can, ea, em, pop;
        wb_entry_t e;
        can = (mq.size() < DEPTH);
        ea = 0; em = 0;
        if (can) begin
          if (alu_valid && mem_valid) begin
            if (losses >= LIMIT) ea = 1; else em = 1;
          end else if (alu_valid) ea = 1;
          else if (mem_valid) em = 1;
        end
        pop = (mq.size() > 0) && !wr_hold;
        chk("alu_ready", alu_ready, ea);
        chk("mem_ready", mem_ready, em);
        chk("wr_enable", wr_enable, pop);
`ifdef REGFILE_WB_PENDING_EN
        begin
          bit p0, p1;
          p0 = 0; p1 = 0;
          foreach (mq[i]) begin
            if (mq[i].addr == rd0_addr) p0 = 1;
            if (mq[i].addr == rd1_addr) p1 = 1;
          end
          chk("rd0_pending", rd0_pending, p0);
          chk("rd1_pending", rd1_pending, p1);
        end
`endif
        if (pop) void'(mq.pop_front());
        if (ea) begin e.addr = alu_addr; e.data = alu_data; mq.push_back(e); exp_q.push_back(e); end
        if (em) begin e.addr = mem_addr; e.data = mem_data; mq.push_back(e); exp_q.push_back(e); end
        if (can) begin
          if (!alu_valid || ea) losses = 0;
          else if (losses < LIMIT) losses++;
        end
      end
    end
  end

  // Sample handshakes just before the edge, then return 1ns after it.
  task automatic step();
    @(negedge clk); #2;
    alu_acc = alu_ready && alu_valid;
    mem_acc = mem_ready && mem_valid;
    @(posedge clk); #1;
  endtask

  initial begin
    int n_acc, waited;
    logic [AW-1:0] seq [5];
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 7; seq[4] = 4;
    alu_valid = 1; mem_valid = 1; wr_hold = 0;
    alu_addr = 3; mem_addr = 4; alu_data = 1; mem_data = 2;
`ifdef REGFILE_WB_PENDING_EN
    rd0_addr = 3; rd1_addr = 6;
`endif
    #2;
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    alu_valid = 0; mem_valid = 0;
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #1;

    // Single ALU write to an empty FIFO.
    alu_valid = 1; alu_addr = 3; alu_data = 32'h5A;
    step();
    chk("t1_accept", alu_acc, 1);
    alu_valid = 0;
    @(negedge clk); #1;
    chk("t1_wr_enable", wr_enable, 1);
    chk("t1_wr_addr", wr_addr, 3);
    chk("t1_wr_data", wr_data, 32'h5A);
    @(posedge clk); @(negedge clk); #1;
    chk("t1_wr_enable_off", wr_enable, 0);
    @(posedge clk); #1;

    // Both producers held valid: three load wins, then a forced ALU win.
    log_q.delete();
    mem_valid = 1; mem_addr = 1; mem_data = $urandom;
    alu_valid = 1; alu_addr = 7; alu_data = $urandom;
    for (int c = 0; c < 12; c++) begin
      step();
      if (mem_acc) begin mem_addr = mem_addr + 1'b1; mem_data = $urandom; end
      if (alu_acc) alu_data = $urandom;
    end
    mem_valid = 0; alu_valid = 0;
    repeat (6) step();
    chk("t2_write_count_ge5", log_q.size() >= 5, 1);
    if (log_q.size() >= 5)
      for (int i = 0; i < 5; i++) chk("t2_wr_addr_seq", log_q[i], seq[i]);

    // Hold: four of five ALU writes buffered, fifth waits for a pop.
    wr_hold = 1; n_acc = 0;
    alu_valid = 1; alu_addr = AW'($urandom); alu_data = $urandom;
    for (int c = 0; c < 10; c++) begin
      step();
      if (alu_acc) begin n_acc++; alu_addr = AW'($urandom); alu_data = $urandom; end
    end
    chk("t3_accepted_under_hold", n_acc, 4);
    wr_hold = 0; waited = 0;
    while (n_acc < 5 && waited < 10) begin
      step();
      waited++;
      if (alu_acc) n_acc++;
    end
    chk("t3_fifth_accepted", n_acc, 5);
    chk("t3_release_latency", waited, 2);
    alu_valid = 0;
    repeat (6) step();

    // Reset mid-cycle with three entries buffered.
    wr_hold = 1; n_acc = 0;
    alu_valid = 1; alu_addr = AW'($urandom); alu_data = $urandom;
    for (int c = 0; c < 8 && n_acc < 3; c++) begin
      step();
      if (alu_acc) begin n_acc++; alu_addr = AW'($urandom); alu_data = $urandom; end
    end
    chk("t4_buffered", n_acc, 3);
    alu_valid = 0; wr_hold = 0;
    mem_valid = 1; mem_addr = 9; mem_data = 32'hCAFE;
    #2 reset = 0;
    #1;
    chk("t4_wr_enable", wr_enable, 0);
    chk("t4_alu_ready", alu_ready, 0);
    chk("t4_mem_ready", mem_ready, 0);
    @(posedge clk); #2 reset = 1;
    log_q.delete();
    for (int c = 0; c < 6; c++) begin
      step();
      if (mem_acc) mem_valid = 0;
    end
    chk("t4_writes_after_reset", log_q.size(), 1);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if (!alu_valid || alu_acc) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_addr = AW'($urandom_range(0, 7)); alu_data = $urandom;
      end
      if (!mem_valid || mem_acc) begin
        mem_valid = ($urandom_range(0, 99) < 60);
        mem_addr = AW'($urandom_range(0, 7)); mem_data = $urandom;
      end
      wr_hold = ($urandom_range(0, 99) < 25);
`ifdef REGFILE_WB_PENDING_EN
      rd0_addr = AW'($urandom_range(0, 7)); rd1_addr = AW'($urandom_range(0, 7));
`endif
      step();
    end
    // Finish any in-flight offers so no handshake is withdrawn.
    for (int c = 0; c < 20 && (alu_valid || mem_valid); c++) begin
      wr_hold = 0;
      step();
      if (alu_acc) alu_valid = 0;
      if (mem_acc) mem_valid = 0;
    end
    alu_valid = 0; mem_valid = 0; wr_hold = 0;
    repeat (8) step();
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
